// File: rtl/fp_ex_sequencer.sv
// Execute-stage sequencer for the FPU: decodes an issued FP instruction, counts
// down its latency, then holds a writeback request until the arbiter grants it.
module fp_ex_sequencer #(
    parameter int unsigned LAT_ADD  = 3,
    parameter int unsigned LAT_MADD = 4,
    parameter int unsigned LAT_CVT  = 2,
    parameter int unsigned CNT_W    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fpu_valid,
    input  logic [31:0] id_inst,
    input  logic        flush,
    output logic        fpu_busy,
    output logic [31:0] ex_fp_inst,
    output logic        op_start,
    output logic [2:0]  op_sel,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic        wb_to_int,
    output logic        illegal
);

    localparam logic [4:0]  OPC_FP_5        = 5'b10100;
    localparam logic [4:0]  OPC_FP_MADD_5   = 5'b10000;
    localparam logic [3:0]  FNC4_FP_ADD     = 4'b0000;
    localparam logic [3:0]  FNC4_FP_FSGNJ_S = 4'b0010;
    localparam logic [3:0]  FNC4_FP_CVT_S_W = 4'b1101;
    localparam logic [3:0]  FNC4_FP_MV_X_W  = 4'b1110;
    localparam logic [3:0]  FNC4_FP_MV_W_X  = 4'b1111;
    localparam logic [31:0] NOP_INST        = 32'h0000_0013;

    localparam logic [2:0] SEL_ADD    = 3'd0;
    localparam logic [2:0] SEL_MADD   = 3'd1;
    localparam logic [2:0] SEL_CVT    = 3'd2;
    localparam logic [2:0] SEL_FSGNJ  = 3'd3;
    localparam logic [2:0] SEL_MV_W_X = 3'd4;
    localparam logic [2:0] SEL_MV_X_W = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [31:0]        inst_nxt;
    logic [2:0]         sel_nxt;
    logic [4:0]         rd_nxt;
    logic               to_int_nxt;
    logic               start_nxt;
    logic               illegal_nxt;

    logic               dec_legal;
    logic [2:0]         dec_sel;
    logic [CNT_W-1:0]   dec_cnt;

    // Instruction decode: class and preloaded countdown (latency - 1)
    always_comb begin
        dec_legal = 1'b0;
        dec_sel   = SEL_ADD;
        dec_cnt   = '0;
        if (id_inst[1:0] == 2'b11) begin
            if (id_inst[6:2] == OPC_FP_MADD_5) begin
                dec_legal = 1'b1;
                dec_sel   = SEL_MADD;
                dec_cnt   = CNT_W'(LAT_MADD - 1);
            end else if (id_inst[6:2] == OPC_FP_5) begin
                case (id_inst[31:28])
                    FNC4_FP_ADD: begin
                        dec_legal = 1'b1;
                        dec_sel   = SEL_ADD;
                        dec_cnt   = CNT_W'(LAT_ADD - 1);
                    end
                    FNC4_FP_CVT_S_W: begin
                        dec_legal = 1'b1;
                        dec_sel   = SEL_CVT;
                        dec_cnt   = CNT_W'(LAT_CVT - 1);
                    end
                    FNC4_FP_FSGNJ_S: begin
                        dec_legal = 1'b1;
                        dec_sel   = SEL_FSGNJ;
                    end
                    FNC4_FP_MV_W_X: begin
                        dec_legal = 1'b1;
                        dec_sel   = SEL_MV_W_X;
                    end
                    FNC4_FP_MV_X_W: begin
                        dec_legal = 1'b1;
                        dec_sel   = SEL_MV_X_W;
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
        end
    end

    // Next state plus next value of every registered output
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        inst_nxt    = ex_fp_inst;
        sel_nxt     = op_sel;
        rd_nxt      = wb_rd;
        to_int_nxt  = wb_to_int;
        start_nxt   = 1'b0;
        illegal_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (fpu_valid && !flush) begin
                    if (dec_legal) begin
                        state_nxt  = S_EXEC;
                        cnt_nxt    = dec_cnt;
                        inst_nxt   = id_inst;
                        sel_nxt    = dec_sel;
                        rd_nxt     = id_inst[11:7];
                        to_int_nxt = (dec_sel == SEL_MV_X_W);
                        start_nxt  = 1'b1;
                    end else begin
                        illegal_nxt = 1'b1;
                    end
                end
            end
            S_EXEC: begin
                if (cnt == '0) begin
                    state_nxt = S_WB;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_WB: begin
                if (wb_ready) begin
                    state_nxt = S_IDLE;
                    inst_nxt  = NOP_INST;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                inst_nxt  = NOP_INST;
            end
        endcase
    end

    // Busy and writeback flags are registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            fpu_busy   <= 1'b0;
            ex_fp_inst <= NOP_INST;
            op_start   <= 1'b0;
            op_sel     <= SEL_ADD;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_to_int  <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            fpu_busy   <= (state_nxt != S_IDLE);
            ex_fp_inst <= inst_nxt;
            op_start   <= start_nxt;
            op_sel     <= sel_nxt;
            wb_valid   <= (state_nxt == S_WB);
            wb_rd      <= rd_nxt;
            wb_to_int  <= to_int_nxt;
            illegal    <= illegal_nxt;
        end
    end

endmodule
